dmem_port_arbiter: RTL and testbench
====================================

DMEM_PORT_ARBITER -- requirements
Module: dmem_port_arbiter

Interface
- REQ-001: The block SHALL have one parameter: STARVE_MAX, default 4, the maximum number of consecutive core grants allowed while a host request waits.
- REQ-002: clk  in  1  the single clock; all state is updated on its rising edge.
- REQ-003: rst_n  in  1  asynchronous, active-low reset.
- REQ-004: core_req  in  1  the pipeline MEM stage needs data port B (MemRead or MemWrite).
- REQ-005: core_we  in  4  core byte-write enables.
- REQ-006: core_addr, core_wdata  in  32 each  core address and store data.
- REQ-007: core_stall  out  1  tells the core pipeline to freeze this cycle.
- REQ-008: core_rdata  out  32  core load data.
- REQ-009: host_valid  in  1  a host/debug request is pending.
- REQ-010: host_ready  out  1  the host request is accepted this cycle.
- REQ-011: host_we  in  4  host byte-write enables; zero means a read.
- REQ-012: host_addr, host_wdata  in  32 each  host address and write data.
- REQ-013: host_lock  in  1  host takes exclusive ownership of the port (program loading).
- REQ-014: host_rvalid  out  1  one-cycle pulse marking valid host read data.
- REQ-015: host_rdata  out  32  host read data.
- REQ-016: bram_web  out  4, bram_addrb  out  32, bram_dib  out  32, bram_dob  in  32: BRAM port B connections.

Function
- REQ-017: The FSM SHALL have three states: ST_CORE (core owns the port), ST_HOST (host owns it for one access), ST_LOCK (host has exclusive ownership).
- REQ-018: Arbitration decision each cycle, in priority order:
  - host_lock=1 -> ST_LOCK.
  - core_req=0 and host_valid=1 -> host granted.
  - core_req=1, host_valid=1 and starve_cnt==STARVE_MAX -> host granted.
  - otherwise -> core granted.
- REQ-019: In a host-grant cycle: host_ready=1; bram_* are driven from host_*; core_stall=core_req.
- REQ-020: In a core-grant cycle: host_ready=0; bram_* are driven from core_*; core_stall=0.
- REQ-021: When no request is granted, bram_web SHALL be 0; bram_addrb/bram_dib hold the core values.
- REQ-022: starve_cnt behaviour:
  - increments by one on each core grant while host_valid=1;
  - saturates at STARVE_MAX;
  - clears to 0 on any host grant or when host_valid=0.
- REQ-023: Host handshake: host_valid and the host_* fields SHALL be held stable until host_ready=1; the transfer completes in the cycle where host_valid=1 and host_ready=1.
- REQ-024: host_rvalid SHALL be registered: it is 1 exactly one cycle after a host read grant (host_we=0). host_rdata=bram_dob in that cycle.
- REQ-025: core_rdata SHALL equal bram_dob combinationally, giving 1-cycle load latency consistent with the WB stage. Its value is don't-care in a cycle following a host grant.
- REQ-026: ST_LOCK behaviour:
  - core_stall=core_req;
  - host_ready=host_valid every cycle (back-to-back accesses);
  - starve_cnt held at 0.
- REQ-027: Leaving ST_LOCK: when host_lock deasserts, the next state is ST_CORE. Any read accepted in the last locked cycle still produces host_rvalid.
- REQ-028: Simultaneous host_lock rising and a core_req: the lock wins in that same cycle; the core stalls.

Reset
- REQ-029: While rst_n=0, the block SHALL force: state=ST_CORE, starve_cnt=0, host_rvalid=0, host_ready=0, core_stall=0, bram_web=0.
- REQ-030: A reset asserted mid-operation SHALL discard any pending host_rvalid; no write is issued during reset.

Structure
- REQ-031: The state encoding (ST_CORE/ST_HOST/ST_LOCK) and STARVE_W=$clog2(STARVE_MAX+1) SHALL live in the shared core package.
- REQ-032: The block SHALL be a single flat module with no sub-module. The arbiter and counter are too small to split.

Verification
- REQ-033: Host-only read: core_req=0, host read addr 0x40 holding 0xDEADBEEF -> host_ready in cycle 0; host_rvalid=1 with host_rdata=0xDEADBEEF in cycle 1.
- REQ-034: Starvation: core_req=1 continuously, host_valid=1 with STARVE_MAX=4 -> four core grants, then host_ready=1 with core_stall=1 in the 5th cycle, then the core resumes.
- REQ-035: Core-only store: core_we=4'b0011, addr 0x100, data 0x0000ABCD -> bram_web=4'b0011 the same cycle; core_stall=0 throughout.
- REQ-036: Locked load: host_lock=1 with 8 back-to-back host writes -> 8 consecutive host_ready cycles; core_stall=1 throughout; bram_web never driven by core.
- REQ-037: Reset mid-read: rst_n=0 in the cycle after a host read grant -> host_rvalid=0, state ST_CORE, starve_cnt=0 after release.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port B arbiter: FSM state encoding
// and starvation-counter sizing.
package dmem_port_arbiter_pkg;

   // Owner of BRAM port B in a given cycle.
   typedef enum logic [1:0] {
      ST_CORE = 2'd0,   // core pipeline owns the port
      ST_HOST = 2'd1,   // host owns the port for a single access
      ST_LOCK = 2'd2    // host holds exclusive ownership (program loading)
   } arb_state_e;

   // Default number of consecutive core grants tolerated while the host waits.
   localparam int STARVE_MAX_DEF = 4;

   // Bits needed to count 0..max_grants inclusive (at least one bit).
   function automatic int starve_width(input int max_grants);
      return (max_grants < 1) ? 1 : $clog2(max_grants + 1);
   endfunction

   // Starvation counter width for the default STARVE_MAX.
   localparam int STARVE_W = starve_width(STARVE_MAX_DEF);

endpackage : dmem_port_arbiter_pkg

// File: rtl/dmem_port_arbiter.sv
// Arbiter sharing BRAM port B between the core MEM stage and a host/debug
// port. The grant is decided combinationally each cycle; a starvation counter
// forces a host grant after STARVE_MAX consecutive core grants, and host_lock
// gives the host exclusive ownership with back-to-back accesses.
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   // core pipeline side
   input  logic        core_req,
   input  logic [3:0]  core_we,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic        core_stall,
   output logic [31:0] core_rdata,
   // host / debug side
   input  logic        host_valid,
   output logic        host_ready,
   input  logic [3:0]  host_we,
   input  logic [31:0] host_addr,
   input  logic [31:0] host_wdata,
   input  logic        host_lock,
   output logic        host_rvalid,
   output logic [31:0] host_rdata,
   // BRAM port B
   output logic [3:0]  bram_web,
   output logic [31:0] bram_addrb,
   output logic [31:0] bram_dib,
   input  logic [31:0] bram_dob
);

   // The package width matches the default; other values are sized here.
   localparam int CNT_W = (STARVE_MAX == STARVE_MAX_DEF) ? STARVE_W
                                                         : starve_width(STARVE_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             host_rvalid_q, host_rvalid_d;
   logic             host_grant;

   // Arbitration decision, port steering and next-state computation.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // through the if/else tree leaves a signal unassigned (no latches).
      state_d       = ST_CORE;
      starve_cnt_d  = '0;
      host_rvalid_d = 1'b0;
      host_grant    = 1'b0;
      host_ready    = 1'b0;
      core_stall    = 1'b0;
      bram_web      = 4'b0000;
      bram_addrb    = core_addr;
      bram_dib      = core_wdata;

      // Reset is asynchronous, so the combinational outputs are quiet too.
      if (rst_n) begin
         if (host_lock) begin
            // Exclusive host ownership: accept every host request, hold core.
            state_d    = ST_LOCK;
            host_grant = host_valid;
            core_stall = core_req;
         end else if (host_valid && (!core_req || (starve_cnt_q == CNT_MAX))) begin
            // Idle core, or the host has waited the maximum number of grants.
            state_d    = ST_HOST;
            host_grant = 1'b1;
            core_stall = core_req;
         end else begin
            state_d = ST_CORE;
            if (core_req) begin
               bram_web = core_we;
            end
            if (host_valid && core_req) begin
               starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX
                                                        : starve_cnt_q + CNT_W'(1);
            end
         end

         if (host_grant) begin
            host_ready    = 1'b1;
            bram_web      = host_we;
            bram_addrb    = host_addr;
            bram_dib      = host_wdata;
            host_rvalid_d = (host_we == 4'b0000);
         end
      end
   end

   // State, starvation counter and read-valid pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_CORE;
         starve_cnt_q  <= '0;
         host_rvalid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together
         // from values computed in the previous cycle.
         state_q       <= state_d;
         starve_cnt_q  <= starve_cnt_d;
         host_rvalid_q <= host_rvalid_d;
      end
   end

   // BRAM read data is registered inside the BRAM: one-cycle load latency.
   assign core_rdata  = bram_dob;
   // Host read data is only meaningful after a host-owned cycle.
   assign host_rdata  = (state_q == ST_CORE) ? 32'h0 : bram_dob;
   assign host_rvalid = host_rvalid_q;

endmodule : dmem_port_arbiter

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic, compared against a cycle-level reference of the
// arbitration rules. Host read data is checked through a scoreboard queue.
module tb_dmem_port_arbiter;
   import dmem_port_arbiter_pkg::*;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        core_req = 1'b0;
   logic [3:0]  core_we = '0;
   logic [31:0] core_addr = '0, core_wdata = '0;
   logic        core_stall;
   logic [31:0] core_rdata;
   logic        host_valid = 1'b0;
   logic        host_ready;
   logic [3:0]  host_we = '0;
   logic [31:0] host_addr = '0, host_wdata = '0;
   logic        host_lock = 1'b0;
   logic        host_rvalid;
   logic [31:0] host_rdata;
   logic [3:0]  bram_web;
   logic [31:0] bram_addrb, bram_dib;
   logic [31:0] bram_dob = '0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_stall(core_stall), .core_rdata(core_rdata),
      .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_lock(host_lock),
      .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .bram_web(bram_web), .bram_addrb(bram_addrb), .bram_dib(bram_dib),
      .bram_dob(bram_dob)
   );

   // Behavioural BRAM port B: read-first, registered output, 64 words.
   logic [31:0] mem [64];
   always @(posedge clk) begin
      bram_dob <= mem[bram_addrb[7:2]];
      for (int b = 0; b < 4; b++)
         if (bram_web[b]) mem[bram_addrb[7:2]][8*b +: 8] <= bram_dib[8*b +: 8];
   end

   // Reference state.
   logic [31:0] ref_mem [64];
   int          ref_cnt = 0;
   bit          exp_rv_now = 1'b0;
   bit          core_rd_pend = 1'b0;
   logic [31:0] core_rd_exp = '0;
   logic [31:0] rd_q [$];

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] we);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // One clock cycle: drive, check combinational outputs, advance the model.
   task automatic step(input bit rst, input bit cr, input logic [3:0] cwe,
                       input logic [31:0] ca, input logic [31:0] cd,
                       input bit hv, input logic [3:0] hwe,
                       input logic [31:0] ha, input logic [31:0] hd,
                       input bit hl, output bit hg);
      logic [3:0]  exp_web;
      rst_n = rst; core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cd;
      host_valid = hv; host_we = hwe; host_addr = ha; host_wdata = hd; host_lock = hl;
      @(negedge clk);
      hg = rst && (hl ? hv : (hv && (!cr || ref_cnt == SM)));
      if (!rst) begin
         exp_rv_now = 1'b0;
         core_rd_pend = 1'b0;
         rd_q.delete();
      end
      check("host_rvalid", host_rvalid, exp_rv_now);
      check("host_ready", host_ready, hg);
      check("core_stall", core_stall, rst && cr && (hl || hg));
      exp_web = !rst ? 4'b0 : hg ? hwe : (!hl && cr) ? cwe : 4'b0;
      check("bram_web", bram_web, exp_web);
      if (rst) begin
         check("bram_addrb", bram_addrb, hg ? ha : ca);
         check("bram_dib", bram_dib, hg ? hd : cd);
      end
      if (core_rd_pend) check("core_rdata", core_rdata, core_rd_exp);
      // advance the reference
      exp_rv_now = hg && (hwe == 4'b0);
      if (exp_rv_now) rd_q.push_back(ref_mem[ha[7:2]]);
      core_rd_pend = rst && !hl && !hg && cr && (cwe == 4'b0);
      core_rd_exp  = ref_mem[ca[7:2]];
      if (hg) ref_mem[ha[7:2]] = merge(ref_mem[ha[7:2]], hd, hwe);
      else if (rst && !hl && cr) ref_mem[ca[7:2]] = merge(ref_mem[ca[7:2]], cd, cwe);
      if (!rst || hl || hg || !hv) ref_cnt = 0;
      else if (cr) ref_cnt = (ref_cnt + 1 > SM) ? SM : ref_cnt + 1;
      @(posedge clk); #1;
   endtask

   // Scoreboard monitor: every host_rvalid pulse consumes one expected word.
   initial forever begin
      @(negedge clk); #1;
      if (host_rvalid === 1'b1) begin
         if (rd_q.size() == 0) check("spurious_rvalid", host_rvalid, 1'b0);
         else check("host_rdata", host_rdata, rd_q.pop_front());
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   bit          g;
   int          n;
   bit          lock_r, hv_p, rst_r, cr_r;
   logic [3:0]  hwe_r, cwe_r;
   logic [31:0] ha_r, hd_r, ca_r, cd_r;

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = (i == 16) ? 32'hDEADBEEF : $urandom;
         ref_mem[i] = mem[i];
      end
      @(posedge clk); #1;

      // Reset state
      step(0, 1, 4'hF, 32'h4, 32'h1, 1, 4'hF, 32'h8, 32'h2, 0, g);
      step(0, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h8, 32'h0, 1, g);
      check("state_reset", dut.state_q, ST_CORE);

      // Host-only read of 0x40
      step(1, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h40, 32'h0, 0, g);
      step(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);

      // Core-only store
      step(1, 1, 4'b0011, 32'h100, 32'h0000ABCD, 0, 4'h0, 32'h0, 32'h0, 0, g);
      step(1, 1, 4'b0000, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);
      step(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);

      // Starvation: four core grants, host wins on the fifth cycle
      n = 0; g = 1'b0;
      while (!g && n < 20) begin
         step(1, 1, 4'h0, 32'h4 * n, 32'h0, 1, 4'hF, 32'h80, 32'h12345678, 0, g);
         n++;
      end
      check("starve_cycles", n, 5);
      step(1, 1, 4'h0, 32'h80, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);

      // Locked load: 8 back-to-back host writes while the core requests
      for (int i = 0; i < 8; i++)
         step(1, 1, 4'hF, 32'h10, 32'hBAD0BAD0, 1, 4'hF, 32'h200 + 32'(4*i), 32'hC0DE0000 + 32'(i), 1, g);
      step(1, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h204, 32'h0, 1, g);
      step(1, 1, 4'h0, 32'h208, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);

      // Reset in the cycle after a host read grant
      step(1, 0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h40, 32'h0, 0, g);
      step(0, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);
      step(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);
      check("state_after_rst", dut.state_q, ST_CORE);
      check("cnt_after_rst", 32'(dut.starve_cnt_q), 32'd0);
      n = 0; g = 1'b0;
      while (!g && n < 20) begin
         step(1, 1, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h40, 32'h0, 0, g);
         n++;
      end
      check("starve_cycles_after_rst", n, 5);

      // Randomized traffic with a held host handshake
      lock_r = 1'b0; hv_p = 1'b0;
      hwe_r = '0; ha_r = '0; hd_r = '0;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 29) == 0) lock_r = ~lock_r;
         if (!hv_p && $urandom_range(0, 2) == 0) begin
            hv_p  = 1'b1;
            hwe_r = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
            ha_r  = {24'b0, 6'($urandom), 2'b00};
            hd_r  = $urandom;
         end
         cr_r  = ($urandom_range(0, 3) != 0);
         cwe_r = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom);
         ca_r  = $urandom;
         cd_r  = $urandom;
         rst_r = ($urandom_range(0, 99) != 0);
         step(rst_r, cr_r, cwe_r, ca_r, cd_r, hv_p, hwe_r, ha_r, hd_r, lock_r, g);
         if (g) hv_p = 1'b0;
      end

      step(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);
      step(1, 0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0, 0, g);
      check("rd_queue_drained", rd_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dmem_port_arbiter
